// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state type and default widths for dmem_loader (honours DMEM_LOADER_CHECKSUM_EN)
package loader_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

`ifdef DMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_LEN, ST_ADDR, ST_DATA, ST_CHK, ST_RUN, ST_HALT, ST_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_LEN, ST_ADDR, ST_DATA, ST_RUN, ST_HALT, ST_ERR
    } state_t;
`endif

endpackage

// File: rtl/dmem_loader.sv
// rtl/dmem_loader.sv - byte-stream frame loader into data memory, holds the core in reset until loaded
// Optional frame checksum byte enabled by DMEM_LOADER_CHECKSUM_EN.
module dmem_loader
    import loader_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          loaded,
    output logic          err
);

    state_t        state;
    state_t        state_nxt;
    logic [AW:0]   n_len;
    logic [AW:0]   cnt;
    logic [AW-1:0] base;
    logic          run_armed;
    logic          accept;
    logic          last_data;

    assign accept    = in_valid && in_ready;
    assign last_data = (cnt + {{AW{1'b0}}, 1'b1}) == n_len;

    // run_armed delays core release by one cycle so the final write lands first
    assign core_reset = !((state == ST_RUN) && run_armed);

`ifdef DMEM_LOADER_CHECKSUM_EN
    logic [DW-1:0] acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (accept) begin
            case (state)
                ST_LEN, ST_HALT:  acc <= in_data;
                ST_ADDR, ST_DATA: acc <= acc ^ in_data;
                default:          acc <= acc;
            endcase
        end
    end

    assign err = (state == ST_ERR);
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        loaded    = 1'b0;
        case (state)
            ST_LEN: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && last_data) begin
`ifdef DMEM_LOADER_CHECKSUM_EN
                    state_nxt = ST_CHK;
`else
                    state_nxt = ST_RUN;
`endif
                end
            end
`ifdef DMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nxt = (in_data == acc) ? ST_RUN : ST_ERR;
            end
`endif
            ST_RUN: begin
                loaded = 1'b1;
                if (core_done) state_nxt = ST_HALT;
            end
            ST_HALT: begin
                in_ready = 1'b1;
                loaded   = 1'b1;
                if (in_valid) state_nxt = ST_ADDR;
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt = ST_LEN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_LEN;
            n_len     <= '0;
            cnt       <= '0;
            base      <= '0;
            run_armed <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_dat   <= '0;
        end else begin
            state     <= state_nxt;
            run_armed <= (state == ST_RUN);
            mem_wr_en <= 1'b0;
            if (accept) begin
                case (state)
                    ST_LEN, ST_HALT: begin
                        // a zero length byte stands for a full 2^AW-byte frame
                        n_len <= (in_data[AW-1:0] == '0) ? {1'b1, {AW{1'b0}}}
                                                         : {1'b0, in_data[AW-1:0]};
                    end
                    ST_ADDR: begin
                        base <= in_data[AW-1:0];
                        cnt  <= '0;
                    end
                    ST_DATA: begin
                        mem_wr_en <= 1'b1;
                        mem_addr  <= base + cnt[AW-1:0];
                        mem_dat   <= in_data;
                        cnt       <= cnt + {{AW{1'b0}}, 1'b1};
                    end
                    default: begin
                        cnt <= cnt;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_loader.sv
// tb/tb_dmem_loader.sv - randomized frame stimulus checked against a frame-level model of dmem_loader
module tb_dmem_loader;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int NMAX = 1 << AW;

    localparam int M_LEN  = 0;
    localparam int M_ADDR = 1;
    localparam int M_DATA = 2;
    localparam int M_CHK  = 3;
    localparam int M_RUN  = 4;
    localparam int M_HALT = 5;
    localparam int M_ERR  = 6;

`ifdef DMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          core_done = 1'b0;
    logic          in_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dat;
    logic          core_reset;
    logic          busy;
    logic          loaded;
    logic          err;

    dmem_loader #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_dat    (mem_dat),
        .core_reset (core_reset),
        .core_done  (core_done),
        .busy       (busy),
        .loaded     (loaded),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Frame-level model: where the loader is in the frame and what the last write was
    int m_st = M_LEN;
    int m_n = 0;
    int m_base = 0;
    int m_idx = 0;
    int m_acc = 0;
    int m_run_age = 0;
    bit e_wr = 1'b0;
    int e_addr = 0;
    int e_dat = 0;
    bit m_acc_b;

    function automatic bit exp_ready();
        return (m_st == M_LEN) || (m_st == M_ADDR) || (m_st == M_DATA) ||
               (m_st == M_CHK) || (m_st == M_HALT);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_st = M_LEN; m_idx = 0; m_acc = 0; m_run_age = 0;
            e_wr = 1'b0; e_addr = 0; e_dat = 0;
        end else begin
            m_acc_b = in_valid && exp_ready();
            e_wr = 1'b0;
            if (m_st == M_RUN) begin
                if (core_done) m_st = M_HALT;
                else m_run_age++;
            end else if (m_acc_b) begin
                case (m_st)
                    M_LEN, M_HALT: begin
                        m_n = (in_data == 0) ? NMAX : int'(in_data);
                        m_acc = int'(in_data);
                        m_st = M_ADDR;
                    end
                    M_ADDR: begin
                        m_base = int'(in_data);
                        m_acc = m_acc ^ int'(in_data);
                        m_idx = 0;
                        m_st = M_DATA;
                    end
                    M_DATA: begin
                        e_wr = 1'b1;
                        e_addr = (m_base + m_idx) % NMAX;
                        e_dat = int'(in_data);
                        m_acc = m_acc ^ int'(in_data);
                        m_idx++;
                        if (m_idx == m_n) begin
                            m_st = CHK_EN ? M_CHK : M_RUN;
                            m_run_age = 0;
                        end
                    end
                    M_CHK: begin
                        m_st = (int'(in_data) == m_acc) ? M_RUN : M_ERR;
                        m_run_age = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    bit chk_on = 1'b0;
    int wr_count = 0;
    logic [DW-1:0] shadow [NMAX];
    bit written [NMAX];

    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready", in_ready, exp_ready());
            chk("busy", busy, (m_st == M_ADDR) || (m_st == M_DATA) || (m_st == M_CHK));
            chk("loaded", loaded, (m_st == M_RUN) || (m_st == M_HALT));
            chk("err", err, m_st == M_ERR);
            chk("core_reset", core_reset, !((m_st == M_RUN) && (m_run_age > 0)));
            chk("mem_wr_en", mem_wr_en, e_wr);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_dat", mem_dat, e_dat);
            if (mem_wr_en === 1'b1) begin
                wr_count++;
                shadow[mem_addr] = mem_dat;
                written[mem_addr] = 1'b1;
            end
        end
    end

    logic [DW-1:0] fbuf [NMAX];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_count = 0;
        for (int i = 0; i < NMAX; i++) written[i] = 1'b0;
    endtask

    task automatic send_byte(input logic [DW-1:0] b, input bit noisy);
        int gap;
        bit r;
        bit done;
        gap = noisy ? int'($urandom_range(0, 2)) : 0;
        for (int i = 0; i < gap; i++) begin
            in_valid = 1'b0;
            core_done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data = b;
        done = 1'b0;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            done = r;
        end
        if (!done) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int len, input int base, input bit bad_chk, input bit noisy);
        int n;
        int x;
        n = (len == 0) ? NMAX : len;
        send_byte(DW'(len), noisy);
        send_byte(DW'(base), noisy);
        x = len ^ base;
        for (int i = 0; i < n; i++) begin
            send_byte(fbuf[i], noisy && (i % 3 == 0));
            x = x ^ int'(fbuf[i]);
        end
`ifdef DMEM_LOADER_CHECKSUM_EN
        send_byte(bad_chk ? 8'h00 : DW'(x), noisy);
`else
        x = x + int'(bad_chk);
`endif
        in_valid = 1'b0;
        core_done = 1'b0;
    endtask

    task automatic wait_loaded();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = (loaded === 1'b1);
        end
        chk("run_reached", seen, 1);
        tick();
        tick();
    endtask

    task automatic finish_run();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        @(negedge clk);
        chk("halt_core_reset", core_reset, 1);
        chk("halt_loaded", loaded, 1);
        tick();
    endtask

    initial begin
        int len;
        int base;
        int cov;

        reset = 1'b1;
        tick();
        chk_on = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        tick();

        // Reference frame: LEN=3, ADDR=0x10, AA BB CC
        clear_log();
        fbuf[0] = 8'hAA; fbuf[1] = 8'hBB; fbuf[2] = 8'hCC;
        send_frame(3, 8'h10, 1'b0, 1'b0);
        wait_loaded();
        chk("f34_count", wr_count, 3);
        chk("f34_10", shadow[8'h10], 8'hAA);
        chk("f34_11", shadow[8'h11], 8'hBB);
        chk("f34_12", shadow[8'h12], 8'hCC);
        chk("f34_core_released", core_reset, 0);
        chk("f34_model_run", m_st, M_RUN);

        // Bytes offered in RUN are ignored
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = DW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("run_ignore_count", wr_count, 3);
        chk("run_still_released", core_reset, 0);
        finish_run();

        // Address wrap from HALT
        clear_log();
        fbuf[0] = 8'h01; fbuf[1] = 8'h02;
        send_frame(2, 8'hFF, 1'b0, 1'b0);
        wait_loaded();
        chk("wrap_count", wr_count, 2);
        chk("wrap_ff", shadow[8'hFF], 8'h01);
        chk("wrap_00", shadow[8'h00], 8'h02);
        finish_run();

        // LEN=0 means a full 2^AW-byte frame
        clear_log();
        for (int i = 0; i < NMAX; i++) fbuf[i] = DW'($urandom);
        send_frame(0, 8'h00, 1'b0, 1'b0);
        wait_loaded();
        chk("len0_model_n", m_n, 256);
        chk("len0_count", wr_count, 256);
        cov = 0;
        for (int i = 0; i < NMAX; i++) cov += int'(written[i]);
        chk("len0_cover", cov, 256);
        finish_run();

        // Random frames with random gaps and stray core_done outside RUN
        for (int f = 0; f < 6; f++) begin
            clear_log();
            len = int'($urandom_range(1, 20));
            base = int'($urandom_range(0, 255));
            for (int i = 0; i < len; i++) fbuf[i] = DW'($urandom);
            send_frame(len, base, 1'b0, 1'b1);
            wait_loaded();
            chk("rand_count", wr_count, len);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
            finish_run();
        end

        // Reset after the second data byte, with a same-cycle offer
        clear_log();
        send_byte(8'd4, 1'b0);
        send_byte(8'h40, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        reset = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h33;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_wr_en", mem_wr_en, 0);
        chk("mid_rst_core_reset", core_reset, 1);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_count", wr_count, 2);
        tick();
        clear_log();
        fbuf[0] = 8'hAA; fbuf[1] = 8'hBB; fbuf[2] = 8'hCC;
        send_frame(3, 8'h10, 1'b0, 1'b0);
        wait_loaded();
        chk("post_rst_count", wr_count, 3);
        chk("post_rst_12", shadow[8'h12], 8'hCC);
        finish_run();

`ifdef DMEM_LOADER_CHECKSUM_EN
        // Bad checksum is sticky until reset
        clear_log();
        send_frame(3, 8'h10, 1'b1, 1'b0);
        tick();
        @(negedge clk);
        chk("bad_chk_err", err, 1);
        chk("bad_chk_core_reset", core_reset, 1);
        chk("bad_chk_in_ready", in_ready, 0);
        chk("bad_chk_count", wr_count, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
